// File: rtl/ifetch_ctrl.sv
// Fetch-stage PC and IF/ID latch controller: addresses a combinational instruction
// memory, holds the fetched word for decode, and takes branch redirects from execute.
module ifetch_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int MEM_DEPTH = 128,
    parameter int RESET_PC  = 0,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_data,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_npc,
    output logic              if_valid,
    input  logic              id_ready,
    output logic [CNT_W-1:0]  fetch_count
);

    // MEM_DEPTH is a power of two, so wrapping is a mask of the low address bits.
    localparam logic [ADDR_W-1:0] PC_MASK  = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_PC);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic              consume;
    logic              advance;

    // Handshake: the IF/ID entry transfers to decode on a rising edge where
    // if_valid and id_ready are both high; if_instr/if_npc hold while if_valid
    // is high and id_ready is low. A fresh word may be captured on the same
    // edge that the old one is consumed.
    assign consume  = if_valid & id_ready;
    assign advance  = fetch_en & (~if_valid | id_ready);
    assign pc_inc   = (pc + ADDR_W'(1)) & PC_MASK;
    assign mem_addr = pc;

    // Redirect wins over fetch: the stale entry is flushed and nothing is captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= PC_RESET;
            if_instr <= '0;
            if_npc   <= '0;
            if_valid <= 1'b0;
        end else if (br_taken) begin
            pc       <= br_target & PC_MASK;
            if_valid <= 1'b0;
        end else if (advance) begin
            pc       <= pc_inc;
            if_instr <= mem_data;
            if_npc   <= pc_inc;
            if_valid <= 1'b1;
        end else if (consume) begin
            if_valid <= 1'b0;
        end
    end

    // Counts decode handoffs, including the one completing alongside a redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= '0;
        end else if (consume) begin
            fetch_count <= fetch_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Randomised and directed bench for ifetch_ctrl: a queue-based fetch model feeds an
// expected-delivery queue that a negedge monitor checks against decode handoffs.
module tb_ifetch_ctrl;

    localparam int ADDR_W = 32;
    localparam int DEPTH  = 128;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              fetch_en = 1'b0;
    logic              br_taken = 1'b0;
    logic [ADDR_W-1:0] br_target = '0;
    logic              id_ready = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic [31:0]       if_instr;
    logic [ADDR_W-1:0] if_npc;
    logic              if_valid;
    logic [CNT_W-1:0]  fetch_count;

    logic [31:0] mem [DEPTH];

    int total = 0;
    int bad   = 0;

    // Reference model: PC, words fetched but not yet taken by decode, and words
    // decode is expected to receive (in order).
    int          m_pc  = 0;
    int          m_cnt = 0;
    logic [63:0] pend_q[$];
    logic [63:0] exp_q[$];

    ifetch_ctrl #(
        .ADDR_W(ADDR_W), .MEM_DEPTH(DEPTH), .RESET_PC(0), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .mem_addr(mem_addr),
        .mem_data(mem_data), .br_taken(br_taken), .br_target(br_target),
        .if_instr(if_instr), .if_npc(if_npc), .if_valid(if_valid),
        .id_ready(id_ready), .fetch_count(fetch_count)
    );

    assign mem_data = mem[mem_addr[6:0]];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pend_q.delete();
        exp_q.delete();
        m_pc  = 0;
        m_cnt = 0;
    endtask

    task automatic model_step(input bit fe, input bit rdy, input bit br, input int tgt);
        int nxt;
        if (pend_q.size() > 0 && rdy) begin
            exp_q.push_back(pend_q.pop_front());
            m_cnt = (m_cnt + 1) % (1 << CNT_W);
        end
        if (br) begin
            pend_q.delete();
            m_pc = tgt % DEPTH;
        end else if (fe && pend_q.size() == 0) begin
            nxt = (m_pc + 1) % DEPTH;
            pend_q.push_back({mem[m_pc], 32'(nxt)});
            m_pc = nxt;
        end
    endtask

    // Called just after a rising edge; drives one cycle and checks the state after the next edge.
    task automatic step(input bit fe, input bit rdy, input bit br, input int tgt);
        fetch_en  = fe;
        id_ready  = rdy;
        br_taken  = br;
        br_target = ADDR_W'(tgt);
        model_step(fe, rdy, br, tgt);
        @(posedge clk);
        #1;
        chk("mem_addr", 64'(mem_addr), 64'(m_pc));
        chk("if_valid", 64'(if_valid), 64'(pend_q.size() != 0));
        chk("fetch_count", 64'(fetch_count), 64'(m_cnt));
    endtask

    // Monitor: every handoff decode will take at the coming edge must match the model.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && if_valid && id_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_handoff", 64'(if_instr), 64'hDEAD_0000_0000_0000);
                end else begin
                    e = exp_q.pop_front();
                    chk("if_instr", 64'(if_instr), 64'(e[63:32]));
                    chk("if_npc", 64'(if_npc), 64'(e[31:0]));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[0] = 32'h002300AA;
        mem[1] = 32'h10654321;
        mem[2] = 32'h00100022;
        mem[3] = 32'h8C123456;

        #1 rst_n = 1'b0;
        #2;
        model_reset();
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_if_valid", 64'(if_valid), 64'd0);
        chk("rst_fetch_count", 64'(fetch_count), 64'd0);
        chk("rst_if_instr", 64'(if_instr), 64'd0);
        chk("rst_if_npc", 64'(if_npc), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Free-run into backpressure on word 1
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("bp_word1", 64'(if_instr), 64'h10654321);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0);
            chk("bp_hold_instr", 64'(if_instr), 64'h10654321);
            chk("bp_hold_npc", 64'(if_npc), 64'd2);
            chk("bp_hold_addr", 64'(mem_addr), 64'd2);
        end
        step(1, 1, 0, 0);
        chk("bp_release", 64'(if_instr), 64'h00100022);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("four_accepts", 64'(fetch_count), 64'd4);

        // Redirect while stalled
        step(1, 0, 1, 6);
        chk("br_flush_valid", 64'(if_valid), 64'd0);
        chk("br_flush_addr", 64'(mem_addr), 64'd6);
        step(1, 0, 0, 0);
        chk("br_target_instr", 64'(if_instr), 64'(mem[6]));
        chk("br_target_npc", 64'(if_npc), 64'd7);

        // PC wrap and out-of-range target
        step(1, 1, 1, 127);
        step(1, 1, 0, 0);
        chk("wrap_npc", 64'(if_npc), 64'd0);
        chk("wrap_addr", 64'(mem_addr), 64'd0);
        step(1, 1, 1, 130);
        chk("tgt_mod_addr", 64'(mem_addr), 64'd2);

        // fetch_en low drains the entry and freezes the PC
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("fe0_valid", 64'(if_valid), 64'd0);
        chk("fe0_addr", 64'(mem_addr), 64'd3);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("fe_resume_instr", 64'(if_instr), 64'h8C123456);
        chk("fe_resume_npc", 64'(if_npc), 64'd4);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) == 0, int'($urandom_range(0, 255)));
        end

        // Asynchronous reset between edges, with a redirect held during reset
        fetch_en = 1'b1;
        id_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_valid", 64'(if_valid), 64'd0);
        chk("async_rst_addr", 64'(mem_addr), 64'd0);
        chk("async_rst_count", 64'(fetch_count), 64'd0);
        br_taken  = 1'b1;
        br_target = 50;
        @(posedge clk);
        #1;
        chk("br_in_reset_addr", 64'(mem_addr), 64'd0);
        br_taken = 1'b0;
        rst_n    = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) == 0, int'($urandom_range(0, 255)));
        end

        // Drain and confirm every expected handoff was seen
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
